// File: rtl/pdm_buffer_ctrl.sv
// Sample buffer controller: external-RAM ring plus a registered output word.
// Optional PDM_BUF_OVERWRITE_EN build drops the oldest RAM word when written while full.
module pdm_buffer_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              dropped,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   head, tail, ram_count;
  logic              full, empty, accept, fetch, drop;

  assign ram_count = head - tail;
  assign full      = (ram_count == DEPTH);
  assign empty     = (ram_count == '0);

`ifdef PDM_BUF_OVERWRITE_EN
  assign wr_ready = !rst;
  assign drop     = accept & full;
`else
  assign wr_ready = !rst & !full;
  assign drop     = 1'b0;
`endif

  assign accept    = wr_valid & wr_ready;
  assign dropped   = drop;
  assign ram_we    = accept;
  assign ram_waddr = head[ADDR_W-1:0];
  assign ram_wdata = wr_data;
  assign ram_re    = fetch;
  assign ram_raddr = tail[ADDR_W-1:0];
  assign level     = ram_count + (ADDR_W+1)'(state != IDLE);

  // Fetch decisions use the registered count, so a word written this cycle
  // is never read back at the same address in the same cycle.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !drop) begin
          fetch     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (!empty && !drop) begin
            fetch     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      head  <= head + (ADDR_W+1)'(accept);
      // fetch and drop are mutually exclusive; a drop advances tail past the lost word
      tail  <= tail + (ADDR_W+1)'(fetch) + (ADDR_W+1)'(drop);
      if (state == FETCH) rd_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_pdm_buffer_ctrl.sv
// Bench for pdm_buffer_ctrl: vector table, directed corner cases and a
// randomized run against a queue model (level = words held, FIFO order).
module tb_pdm_buffer_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0, wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid, rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   level;
  logic              dropped;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  pdm_buffer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .dropped(dropped),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] q[$];

  typedef struct {
    logic              wv;
    logic [DATA_W-1:0] wd;
    logic              rr;
    logic              e_rv;
    logic [DATA_W-1:0] e_rd;
    int                e_lvl;
    logic              e_we;
    logic              e_re;
  } vec_t;
  vec_t tv[9];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Called at a negedge: drive, check against the model, advance one cycle.
  task automatic step(input logic wv, input logic [DATA_W-1:0] wd, input logic rr,
                      output logic acc);
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("dropped_idle", 32'(dropped), 0);
`ifdef PDM_BUF_OVERWRITE_EN
    chk("wr_ready_ow", 32'(wr_ready), 1);
`else
    if (q.size() < DEPTH)  chk("wr_ready_room", 32'(wr_ready), 1);
    if (q.size() == DEPTH + 1) chk("wr_ready_full", 32'(wr_ready), 0);
`endif
    acc = wv && wr_ready;
    chk("ram_we", 32'(ram_we), 32'(acc));
    if (acc) chk("ram_wdata", 32'(ram_wdata), 32'(wd));
    if (rd_valid && rr) begin
      if (q.size() == 0) chk("unexpected_word", 32'(rd_data), 32'hFFFF_FFFF);
      else chk("rd_data", 32'(rd_data), 32'(q.pop_front()));
    end
    if (acc) q.push_back(wd);
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    logic a;
    for (int i = 0; i < bound && q.size() != 0; i++) step(1'b0, '0, 1'b1, a);
    chk("drain_timeout", 32'(q.size()), 0);
    step(1'b0, '0, 1'b0, a);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; rd_ready = 1'b0; rst = 1'b1; q.delete();
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_dropped", 32'(dropped), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic a;
    int   n;
    // Three back-to-back writes drained at full rate: FETCH bubble before each word.
    tv[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1, 1'b1, 1'b1};
    tv[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 2, 1'b1, 1'b0};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 3, 1'b0, 1'b1};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 2, 1'b0, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
    tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    foreach (tv[i]) begin
      wr_valid = tv[i].wv; wr_data = tv[i].wd; rd_ready = tv[i].rr;
      #1;
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(tv[i].e_rv));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].e_lvl));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(tv[i].e_we));
      chk($sformatf("vec%0d_ram_re", i), 32'(ram_re), 32'(tv[i].e_re));
      if (tv[i].e_rv) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(tv[i].e_rd));
      @(negedge clk);
    end

    // Single write into an empty buffer: read issued only in the following cycle.
    do_reset();
    wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b0;
    #1;
    chk("single_we", 32'(ram_we), 1);
    chk("single_re_same", 32'(ram_re), 0);
    q.push_back(8'h77);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("single_re_next", 32'(ram_re), 1);
    chk("single_raddr", 32'(ram_raddr), 0);
    @(negedge clk);
    drain(20);

    // Reset while a fetch is in flight with five words held.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, a);
    step(1'b0, '0, 1'b1, a);
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("pre_rst_level", 32'(level), 5);
    chk("pre_rst_fetch", 32'(rd_valid), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_valid", 32'(rd_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b1, a);
    drain(20);

`ifndef PDM_BUF_OVERWRITE_EN
    // Fill with the consumer stalled: 512 RAM words plus the output register.
    do_reset();
    n = 0;
    for (int i = 0; i < 530; i++) begin
      step(1'b1, 8'(i), 1'b0, a);
      if (a) n++;
    end
    chk("fill_accepts", 32'(n), 513);
    wr_valid = 1'b1;
    #1;
    chk("fill_level", 32'(level), 513);
    chk("fill_wr_ready", 32'(wr_ready), 0);
    chk("fill_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    drain(2000);

    // Stream 2000 words at one per cycle with the consumer always ready.
    do_reset();
    n = 0;
    for (int i = 0; i < 6000 && n < 2000; i++) begin
      step(1'b1, 8'($urandom), 1'b1, a);
      if (a) n++;
    end
    chk("stream_count", 32'(n), 2000);
    drain(2000);
`else
    // Overwrite: fill, then one more write drops the oldest RAM word.
    do_reset();
    for (int i = 0; i < 513; i++) step(1'b1, 8'(i), 1'b0, a);
    wr_valid = 1'b1; wr_data = 8'hAA; rd_ready = 1'b0;
    #1;
    chk("ow_dropped", 32'(dropped), 1);
    chk("ow_ram_we", 32'(ram_we), 1);
    chk("ow_level_before", 32'(level), 513);
    q.delete(1);
    q.push_back(8'hAA);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("ow_dropped_once", 32'(dropped), 0);
    chk("ow_level_after", 32'(level), 513);
    @(negedge clk);
    drain(2000);
`endif

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic wv;
      wv = 1'($urandom);
`ifdef PDM_BUF_OVERWRITE_EN
      if (q.size() >= DEPTH - 4) wv = 1'b0;
`endif
      step(wv, 8'($urandom), 1'($urandom_range(0, 2) != 0), a);
    end
    drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
